// File: rtl/dec_scan_ctrl.sv
// Scan sequencer for a 4-to-16 decoder: walks the enabled lines in ascending order,
// holding each for DWELL cycles with GAP blank cycles in between.
module dec_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Continuous,
  input  logic [15:0] Mask,
  output logic [3:0]  W,
  output logic        Enable,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_mask;
  logic             r_cont;
  logic [3:0]       r_w;
  logic [3:0]       r_next_w;
  logic             r_enable;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_cnt_d;
  logic [15:0]      w_mask_d;
  logic             w_cont_d;
  logic [3:0]       w_w_d;
  logic [3:0]       w_next_w_d;
  logic             w_enable_d;
  logic             w_busy_d;
  logic             w_done_d;

  logic [4:0]       w_new_srch;
  logic [4:0]       w_nxt_srch;
  logic             w_new_any;
  logic [3:0]       w_new_idx;
  logic             w_next_any;
  logic [3:0]       w_next_idx;
  logic             w_advance;
  logic [3:0]       w_adv_idx;
  logic             w_dwell_end;
  logic             w_gap_end;
  logic             w_start_ok;

  // Lowest set index at or above floor_idx; bit 4 flags that one was found.
  function automatic logic [4:0] lowest_from(input logic [15:0] m, input logic [4:0] floor_idx);
    logic [4:0] res;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (i >= int'(floor_idx))) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  always_comb begin
    w_new_srch = lowest_from(Mask, 5'd0);
    w_nxt_srch = lowest_from(r_mask, {1'b0, r_w} + 5'd1);
  end

  assign w_new_any   = w_new_srch[4];
  assign w_new_idx   = w_new_srch[3:0];
  assign w_next_any  = w_nxt_srch[4];
  assign w_next_idx  = w_nxt_srch[3:0];
  // A continuous sweep wraps by re-capturing the live Mask only when the current one is exhausted.
  assign w_advance   = w_next_any || (r_cont && w_new_any);
  assign w_adv_idx   = w_next_any ? w_next_idx : w_new_idx;
  assign w_dwell_end = (r_cnt == DWELL_LAST);
  assign w_gap_end   = (r_cnt == GAP_LAST);
  assign w_start_ok  = Start && !Stop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_cont   <= 1'b0;
      r_w      <= '0;
      r_next_w <= '0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_d;
      r_mask   <= w_mask_d;
      r_cont   <= w_cont_d;
      r_w      <= w_w_d;
      r_next_w <= w_next_w_d;
      r_enable <= w_enable_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok && w_new_any) w_state_nxt = ST_DWELL;
      end
      ST_DWELL: begin
        if (Stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_dwell_end) begin
          if (!w_advance)   w_state_nxt = ST_IDLE;
          else if (GAP > 0) w_state_nxt = ST_GAP;
          else              w_state_nxt = ST_DWELL;
        end
      end
      ST_GAP: begin
        if (Stop)           w_state_nxt = ST_IDLE;
        else if (w_gap_end) w_state_nxt = ST_DWELL;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_cnt_d    = r_cnt + CNT_W'(1);
    w_mask_d   = r_mask;
    w_cont_d   = r_cont;
    w_w_d      = r_w;
    w_next_w_d = r_next_w;
    w_enable_d = r_enable;
    w_busy_d   = r_busy;
    w_done_d   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_d    = '0;
        w_w_d      = '0;
        w_enable_d = 1'b0;
        w_busy_d   = 1'b0;
        if (w_start_ok) begin
          w_mask_d = Mask;
          w_cont_d = Continuous;
          if (w_new_any) begin
            w_w_d      = w_new_idx;
            w_enable_d = 1'b1;
            w_busy_d   = 1'b1;
          end else begin
            w_done_d = 1'b1;
          end
        end
      end
      ST_DWELL: begin
        if (Stop) begin
          w_cnt_d    = '0;
          w_w_d      = '0;
          w_enable_d = 1'b0;
          w_busy_d   = 1'b0;
        end else if (w_dwell_end) begin
          w_cnt_d = '0;
          if (!w_next_any && r_cont) w_mask_d = Mask;
          if (!w_advance) begin
            w_w_d      = '0;
            w_enable_d = 1'b0;
            w_busy_d   = 1'b0;
            w_done_d   = 1'b1;
          end else if (GAP > 0) begin
            w_enable_d = 1'b0;
            w_next_w_d = w_adv_idx;
          end else begin
            w_w_d = w_adv_idx;
          end
        end
      end
      ST_GAP: begin
        if (Stop) begin
          w_cnt_d    = '0;
          w_w_d      = '0;
          w_enable_d = 1'b0;
          w_busy_d   = 1'b0;
        end else if (w_gap_end) begin
          w_cnt_d    = '0;
          w_w_d      = r_next_w;
          w_enable_d = 1'b1;
        end
      end
      default: begin
        w_cnt_d    = '0;
        w_w_d      = '0;
        w_enable_d = 1'b0;
        w_busy_d   = 1'b0;
      end
    endcase
  end

  assign W      = r_w;
  assign Enable = r_enable;
  assign Busy   = r_busy;
  assign Done   = r_done;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Directed bench for dec_scan_ctrl: a DWELL=2/GAP=1 instance plus a DWELL=2/GAP=0
// instance sharing the same stimulus, checked against hand-computed output sequences.
module tb_dec_scan_ctrl;

  logic        Clock;
  logic        Resetn;
  logic        Start;
  logic        Stop;
  logic        Continuous;
  logic [15:0] Mask;
  logic [3:0]  W,      g0_w;
  logic        Enable, g0_enable;
  logic        Busy,   g0_busy;
  logic        Done,   g0_done;

  int n_checks = 0;
  int n_errors = 0;

  dec_scan_ctrl #(.DWELL(2), .GAP(1)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .Continuous(Continuous), .Mask(Mask),
    .W(W), .Enable(Enable), .Busy(Busy), .Done(Done)
  );

  dec_scan_ctrl #(.DWELL(2), .GAP(0)) dut_g0 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .Continuous(Continuous), .Mask(Mask),
    .W(g0_w), .Enable(g0_enable), .Busy(g0_busy), .Done(g0_done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Outputs packed as {W, Enable, Busy, Done}.
  task automatic expect_out(input string tag, input logic [3:0] w, input logic en,
                            input logic busy, input logic done);
    check(tag, {25'd0, W, Enable, Busy, Done}, {25'd0, w, en, busy, done});
  endtask

  task automatic expect_g0(input string tag, input logic [3:0] w, input logic en,
                           input logic busy, input logic done);
    check(tag, {25'd0, g0_w, g0_enable, g0_busy, g0_done}, {25'd0, w, en, busy, done});
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Single sweep over lines 0 and 15; optionally re-pulses Start while busy.
  task automatic run_two_line_sweep(input string tag, input bit reassert);
    logic [6:0] exp_seq [7];
    exp_seq[0] = {4'd0,  1'b1, 1'b1, 1'b0};
    exp_seq[1] = {4'd0,  1'b1, 1'b1, 1'b0};
    exp_seq[2] = {4'd0,  1'b0, 1'b1, 1'b0};
    exp_seq[3] = {4'd15, 1'b1, 1'b1, 1'b0};
    exp_seq[4] = {4'd15, 1'b1, 1'b1, 1'b0};
    exp_seq[5] = {4'd0,  1'b0, 1'b0, 1'b1};
    exp_seq[6] = {4'd0,  1'b0, 1'b0, 1'b0};
    Mask       = 16'b1000_0000_0000_0001;
    Continuous = 1'b0;
    Start      = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_out($sformatf("%s_e%0d", tag, i), exp_seq[i][6:3], exp_seq[i][2],
                 exp_seq[i][1], exp_seq[i][0]);
      Start = reassert && (i == 1 || i == 2);
    end
  endtask

  initial begin
    Resetn     = 1'b0;
    Start      = 1'b0;
    Stop       = 1'b0;
    Continuous = 1'b0;
    Mask       = '0;
    #3;
    expect_out("reset_async", 4'd0, 1'b0, 1'b0, 1'b0);
    expect_g0("g0_reset_async", 4'd0, 1'b0, 1'b0, 1'b0);
    #20;
    Resetn = 1'b1;
    tick();
    tick();
    expect_out("reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // Two-line single sweep: 2 dwell, 1 gap, 2 dwell, then Done.
    run_two_line_sweep("single", 1'b0);

    // Empty mask: Done pulse only.
    Mask  = '0;
    Start = 1'b1;
    tick();
    expect_out("empty_done", 4'd0, 1'b0, 1'b0, 1'b1);
    Start = 1'b0;
    tick();
    expect_out("empty_after", 4'd0, 1'b0, 1'b0, 1'b0);

    // Continuous on line 3, mask switched to line 7 mid-dwell; takes effect at the wrap.
    Mask       = 16'h0008;
    Continuous = 1'b1;
    Start      = 1'b1;
    tick();
    expect_out("cont_e0", 4'd3, 1'b1, 1'b1, 1'b0);
    Start      = 1'b0;
    Continuous = 1'b0;
    tick(); expect_out("cont_e1", 4'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("cont_e2", 4'd3, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("cont_e3", 4'd3, 1'b1, 1'b1, 1'b0);
    Mask = 16'h0080;
    tick(); expect_out("cont_e4", 4'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("cont_e5", 4'd3, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("cont_e6", 4'd7, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("cont_e7", 4'd7, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("cont_e8", 4'd7, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("cont_e9", 4'd7, 1'b1, 1'b1, 1'b0);
    Stop = 1'b1;
    tick(); expect_out("cont_stop", 4'd0, 1'b0, 1'b0, 1'b0);
    Stop = 1'b0;

    // All lines, Stop in the second dwell cycle of line 5.
    Mask  = 16'hFFFF;
    Start = 1'b1;
    tick();
    expect_out("all_e0", 4'd0, 1'b1, 1'b1, 1'b0);
    Start = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      expect_out($sformatf("all_e%0d", e), 4'(e / 3), (e % 3) != 2, 1'b1, 1'b0);
    end
    Stop = 1'b1;
    tick(); expect_out("all_stop", 4'd0, 1'b0, 1'b0, 1'b0);
    Stop = 1'b0;
    tick(); expect_out("all_stop_hold", 4'd0, 1'b0, 1'b0, 1'b0);
    Start = 1'b1;
    tick(); expect_out("all_restart", 4'd0, 1'b1, 1'b1, 1'b0);
    Start = 1'b0;
    Stop  = 1'b1;
    tick(); expect_out("all_restart_stop", 4'd0, 1'b0, 1'b0, 1'b0);
    Stop = 1'b0;

    // Asynchronous reset between edges in the middle of a dwell.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    expect_out("rst_pre", 4'd0, 1'b1, 1'b1, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    expect_out("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("rst_idle%0d", i), 4'd0, 1'b0, 1'b0, 1'b0);
    end

    // Start re-pulsed while busy leaves the sweep timing unchanged.
    run_two_line_sweep("restart_busy", 1'b1);

    // Start and Stop together in IDLE: nothing happens.
    Mask  = 16'hFFFF;
    Start = 1'b1;
    Stop  = 1'b1;
    tick(); expect_out("start_stop_a", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("start_stop_b", 4'd0, 1'b0, 1'b0, 1'b0);
    Start = 1'b0;
    Stop  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    expect_g0("g0_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // GAP=0 instance: lines 2, 3, 9 back to back with Enable held high.
    Mask  = 16'h020C;
    Start = 1'b1;
    tick(); expect_g0("g0_e0", 4'd2, 1'b1, 1'b1, 1'b0);
    Start = 1'b0;
    tick(); expect_g0("g0_e1", 4'd2, 1'b1, 1'b1, 1'b0);
    tick(); expect_g0("g0_e2", 4'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_g0("g0_e3", 4'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_g0("g0_e4", 4'd9, 1'b1, 1'b1, 1'b0);
    tick(); expect_g0("g0_e5", 4'd9, 1'b1, 1'b1, 1'b0);
    tick(); expect_g0("g0_e6", 4'd0, 1'b0, 1'b0, 1'b1);
    tick(); expect_g0("g0_e7", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
